// File: rtl/ripemd160_pkg.sv
// Shared constants and types for the RIPEMD-160 core and its message padder.
// Holds block geometry, the padding marker, FSM encodings and the H0 chaining values.
package ripemd160_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFFSET  = 56;
  localparam int IDX_W       = 6;

  localparam logic [7:0]       PAD_BYTE = 8'h80;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [IDX_W-1:0] MAX_PAD_IDX = IDX_W'(LEN_OFFSET - 1);

  // Initial chaining value h0..h4 used by the compression core.
  localparam logic [159:0] H0 = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                 32'h10325476, 32'hC3D2E1F0};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    PAD   = 3'd2,
    LEN   = 3'd3,
    ISSUE = 3'd4,
    WAIT  = 3'd5
  } state_t;

endpackage

// File: rtl/ripemd160_block_buf.sv
// 64-byte block assembly buffer: byte writes, 0x80 marker plus tail zeroing,
// little-endian length insertion and a synchronous clear. Byte i drives block[511-8*i -: 8].
module ripemd160_block_buf
  import ripemd160_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wr_data,
  input  logic             pad_en,
  input  logic             len_en,
  input  logic [63:0]      bit_len,
  output logic [511:0]     block
);

  logic [7:0] mem [BLOCK_BYTES];

  // NOTE: this array is reset on purpose -- the block output must read all-zero
  // after reset, so it is built from flops rather than inferred as a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < BLOCK_BYTES; j++) mem[j] <= '0;
    end else if (clr) begin
      for (int j = 0; j < BLOCK_BYTES; j++) mem[j] <= '0;
    end else begin
      if (wr_en) mem[idx] <= wr_data;
      if (pad_en) begin
        for (int j = 0; j < BLOCK_BYTES; j++) begin
          if (IDX_W'(j) == idx)     mem[j] <= PAD_BYTE;
          else if (IDX_W'(j) > idx) mem[j] <= '0;
        end
      end
      // Bit length is stored least-significant byte first.
      if (len_en) begin
        for (int k = 0; k < 8; k++) mem[LEN_OFFSET + k] <= bit_len[8*k +: 8];
      end
    end
  end

  for (genvar i = 0; i < BLOCK_BYTES; i++) begin : g_out
    assign block[511-8*i -: 8] = mem[i];
  end

endmodule

// File: rtl/ripemd160_msg_padder.sv
// Byte-stream front end for the RIPEMD-160 core: assembles 512-bit blocks, applies
// MD-style padding with a little-endian bit length, and hands blocks over via init/next.
module ripemd160_msg_padder
  import ripemd160_pkg::*;
#(
  parameter int LEN_BYTES_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         msg_start,
  input  logic         msg_empty,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  input  logic         core_ready,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] block,
  output logic         msg_done,
  output logic         busy
);

  state_t                 state, next_state;
  logic [IDX_W-1:0]       idx;
  logic [LEN_BYTES_W-1:0] len;
  logic                   first_blk;
  logic                   last_flag;
  logic                   pad_pending;
  logic                   len_pending;

  logic buf_clr, buf_wr, buf_pad, buf_len;
  logic [63:0] bit_len;

  assign bit_len = 64'({len, 3'b000});
  assign busy    = (state != IDLE);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned -- otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    core_init  = 1'b0;
    core_next  = 1'b0;
    msg_done   = 1'b0;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    buf_pad    = 1'b0;
    buf_len    = 1'b0;
    case (state)
      IDLE: begin
        if (msg_start) begin
          buf_clr    = 1'b1;
          next_state = msg_empty ? PAD : FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_wr = 1'b1;
          if (idx == LAST_IDX) next_state = ISSUE;
          else if (in_last)    next_state = PAD;
        end
      end
      PAD: begin
        buf_pad    = 1'b1;
        next_state = (idx <= MAX_PAD_IDX) ? LEN : ISSUE;
      end
      LEN: begin
        buf_len    = 1'b1;
        next_state = ISSUE;
      end
      ISSUE: begin
        if (core_ready) begin
          core_init  = first_blk;
          core_next  = !first_blk;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // Ready high here means the core has taken the block, whether or not
        // it was ever seen low.
        if (core_ready) begin
          if (last_flag) begin
            msg_done   = 1'b1;
            next_state = IDLE;
          end else begin
            buf_clr = 1'b1;
            if (pad_pending)      next_state = PAD;
            else if (len_pending) next_state = LEN;
            else                  next_state = FILL;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      len         <= '0;
      first_blk   <= 1'b0;
      last_flag   <= 1'b0;
      pad_pending <= 1'b0;
      len_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (msg_start) begin
            idx         <= '0;
            len         <= '0;
            first_blk   <= 1'b1;
            last_flag   <= 1'b0;
            pad_pending <= 1'b0;
            len_pending <= 1'b0;
          end
        end
        FILL: begin
          if (in_valid) begin
            idx <= idx + 1'b1;
            len <= len + 1'b1;
            if (in_last && idx == LAST_IDX) pad_pending <= 1'b1;
          end
        end
        PAD: begin
          pad_pending <= 1'b0;
          if (idx > MAX_PAD_IDX) len_pending <= 1'b1;
        end
        LEN: begin
          len_pending <= 1'b0;
          last_flag   <= 1'b1;
        end
        ISSUE: begin
          if (core_ready) first_blk <= 1'b0;
        end
        WAIT: begin
          if (core_ready && !last_flag) idx <= '0;
        end
        default: ;
      endcase
    end
  end

  ripemd160_block_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .idx     (idx),
    .wr_data (in_data),
    .pad_en  (buf_pad),
    .len_en  (buf_len),
    .bit_len (bit_len),
    .block   (block)
  );

endmodule

// File: tb/tb_ripemd160_msg_padder.sv
// Directed bench for ripemd160_msg_padder: a small core model captures each strobed
// block, which is compared against hand-built padded blocks.
module tb_ripemd160_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         msg_start, msg_empty;
  logic         in_valid, in_last;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         core_ready;
  logic         core_init, core_next;
  logic [511:0] block;
  logic         msg_done, busy;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_init, n_next, n_done, n_strobe;
  int init_cyc, last_cyc, stray;
  bit hold = 1'b0;
  logic [511:0] cap [0:7];
  logic [7:0]   msg [0:127];
  logic [511:0] exp0, exp1, exp_abc;

  ripemd160_msg_padder dut (
    .clk        (clk),
    .reset      (reset),
    .msg_start  (msg_start),
    .msg_empty  (msg_empty),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .core_ready (core_ready),
    .core_init  (core_init),
    .core_next  (core_next),
    .block      (block),
    .msg_done   (msg_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (msg_done) n_done++;

  // Core model: on a strobe, capture the block, drop ready the cycle after, raise it 3 cycles later.
  initial begin
    core_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (core_init || core_next) begin
        if (n_strobe < 8) cap[n_strobe] = block;
        n_strobe++;
        if (core_init) begin n_init++; init_cyc = cyc; end
        if (core_next) n_next++;
        @(posedge clk); #1 core_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 core_ready = !hold;
      end else begin
        core_ready = !hold;
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int i, input logic [7:0] v);
    logic [511:0] r;
    r = b;
    r[511-8*i -: 8] = v;
    return r;
  endfunction

  task automatic clear_stats();
    n_init = 0; n_next = 0; n_done = 0; n_strobe = 0;
    init_cyc = -1; last_cyc = -1; stray = 0;
    for (int k = 0; k < 8; k++) cap[k] = '0;
  endtask

  task automatic start_msg(input bit empty);
    @(negedge clk);
    msg_start = 1'b1; msg_empty = empty;
    @(negedge clk);
    msg_start = 1'b0; msg_empty = 1'b0;
  endtask

  task automatic feed(input int n, input bit with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = msg[i]; in_last = with_last && (i == n - 1);
      t = 0;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("in_ready_timeout", 0, 1);
      if (i == n - 1) last_cyc = cyc + 1;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Runs one message; junk bytes stay offered after the last byte and must not be taken.
  task automatic run_msg(input int n);
    int t;
    clear_stats();
    start_msg(n == 0);
    feed(n, 1'b1);
    in_valid = 1'b1; in_data = 8'hEE;
    t = 0;
    while (n_done == 0 && t < 300) begin
      if (in_ready) stray++;
      @(negedge clk); t++;
    end
    in_valid = 1'b0;
    if (t >= 300) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unstable;
    reset = 1'b1; msg_start = 1'b0; msg_empty = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_ctrl", {in_ready, core_init, core_next, msg_done, busy}, '0);
    check("rst_block", block, '0);
    reset = 1'b0;

    // Test 1: 'abc'
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    exp_abc = '0;
    for (int i = 0; i < 3; i++) exp_abc = put(exp_abc, i, msg[i]);
    exp_abc = put(exp_abc, 3, 8'h80);
    exp_abc = put(exp_abc, 56, 8'h18);
    run_msg(3);
    check("t1_init", n_init, 1);
    check("t1_next", n_next, 0);
    check("t1_block", cap[0], exp_abc);
    check("t1_done", n_done, 1);
    check("t1_latency", init_cyc - last_cyc, 2);
    check("t1_busy_idle", busy, 0);

    // Test 2: 55 x 0x41
    for (int i = 0; i < 55; i++) msg[i] = 8'h41;
    exp0 = '0;
    for (int i = 0; i < 55; i++) exp0 = put(exp0, i, 8'h41);
    exp0 = put(exp0, 55, 8'h80);
    exp0 = put(exp0, 56, 8'hB8);
    exp0 = put(exp0, 57, 8'h01);
    run_msg(55);
    check("t2_strobes", {n_init[7:0], n_next[7:0]}, 16'h0100);
    check("t2_block", cap[0], exp0);
    check("t2_done", n_done, 1);

    // Test 3: 56 x 0x42
    for (int i = 0; i < 56; i++) msg[i] = 8'h42;
    exp0 = '0;
    for (int i = 0; i < 56; i++) exp0 = put(exp0, i, 8'h42);
    exp0 = put(exp0, 56, 8'h80);
    exp1 = '0;
    exp1 = put(exp1, 56, 8'hC0);
    exp1 = put(exp1, 57, 8'h01);
    run_msg(56);
    check("t3_strobes", {n_init[7:0], n_next[7:0]}, 16'h0101);
    check("t3_block0", cap[0], exp0);
    check("t3_block1", cap[1], exp1);
    check("t3_done", n_done, 1);

    // Test 4: 64 x 0x43
    for (int i = 0; i < 64; i++) msg[i] = 8'h43;
    exp0 = '0;
    for (int i = 0; i < 64; i++) exp0 = put(exp0, i, 8'h43);
    exp1 = '0;
    exp1 = put(exp1, 0, 8'h80);
    exp1 = put(exp1, 57, 8'h02);
    run_msg(64);
    check("t4_strobes", {n_init[7:0], n_next[7:0]}, 16'h0101);
    check("t4_block0", cap[0], exp0);
    check("t4_block1", cap[1], exp1);
    check("t4_in_ready_low", stray, 0);
    check("t4_done", n_done, 1);

    // Test 5: empty message
    exp0 = '0;
    exp0 = put(exp0, 0, 8'h80);
    run_msg(0);
    check("t5_strobes", {n_init[7:0], n_next[7:0]}, 16'h0100);
    check("t5_block", cap[0], exp0);
    check("t5_done", n_done, 1);

    // Test 6: core held not-ready, then reset in ISSUE and mid-FILL
    clear_stats();
    @(negedge clk); hold = 1'b1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    start_msg(1'b0);
    feed(3, 1'b1);
    repeat (3) @(negedge clk);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      if (block !== exp_abc) unstable++;
      @(negedge clk);
    end
    check("t6_no_strobe", n_strobe, 0);
    check("t6_stable", unstable, 0);
    check("t6_busy", busy, 1);
    reset = 1'b1; #1;
    check("t6_rst_ctrl", {in_ready, core_init, core_next, msg_done, busy}, '0);
    check("t6_rst_block", block, '0);
    @(negedge clk); reset = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_no_strobe_after_rst", n_strobe, 0);

    start_msg(1'b0);
    feed(2, 1'b0);
    check("t6_fill_ready", in_ready, 1);
    reset = 1'b1; #1;
    check("t6_fill_rst_ctrl", {in_ready, core_init, core_next, msg_done, busy}, '0);
    check("t6_fill_rst_block", block, '0);
    @(negedge clk); reset = 1'b0;

    run_msg(3);
    check("t6_abc_init", n_init, 1);
    check("t6_abc_next", n_next, 0);
    check("t6_abc_block", cap[0], exp_abc);
    check("t6_abc_done", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
